// File: rtl/argmax_stream.sv
// Streaming FP16 arg-max/arg-min classifier head: one score per beat, winner index/value at end.
// Optional runner-up tracking is enabled with `define ARGMAX_RUNNER_UP_EN.
module argmax_stream #(
    parameter  int unsigned N_ELEM = 10,
    parameter  int unsigned EXP_W  = 5,
    parameter  int unsigned MAN_W  = 10,
    localparam int unsigned DATA_W = 1 + EXP_W + MAN_W,
    localparam int unsigned IDX_W  = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_min,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_val
`ifdef ARGMAX_RUNNER_UP_EN
   ,output logic [IDX_W-1:0]  ru_idx,
    output logic [DATA_W-1:0] ru_val
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt;
    logic               mode;
    logic [DATA_W-1:0]  best_val, best_val_nx;
    logic [IDX_W-1:0]   best_idx, best_idx_nx;
    logic               beat, last, new_best;

    // Strict "a beats b": NaN never wins, any non-NaN beats NaN, -0 and +0 map to the same key.
    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    input logic mn);
        logic               a_nan, b_nan, res;
        logic signed [DATA_W-1:0] ka, kb;
        a_nan = (&a[DATA_W-2:MAN_W]) && (|a[MAN_W-1:0]);
        b_nan = (&b[DATA_W-2:MAN_W]) && (|b[MAN_W-1:0]);
        ka    = signed'({1'b0, a[DATA_W-2:0]});
        kb    = signed'({1'b0, b[DATA_W-2:0]});
        if (a[DATA_W-1]) ka = -ka;
        if (b[DATA_W-1]) kb = -kb;
        if (a_nan)      res = 1'b0;
        else if (b_nan) res = 1'b1;
        else            res = mn ? (ka < kb) : (ka > kb);
        return res;
    endfunction

    assign beat = in_valid & in_ready;
    assign last = beat && (cnt == IDX_W'(N_ELEM - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Best-so-far including the beat in flight, so the final beat lands in res_* directly.
    always_comb begin
        best_val_nx = best_val;
        best_idx_nx = best_idx;
        new_best    = 1'b0;
        if (beat && ((cnt == '0) || better(in_data, best_val, mode))) begin
            new_best    = 1'b1;
            best_val_nx = in_data;
            best_idx_nx = cnt;
        end
    end

`ifdef ARGMAX_RUNNER_UP_EN
    logic [DATA_W-1:0] ru_val_r, ru_val_nx;
    logic [IDX_W-1:0]  ru_idx_r, ru_idx_nx;
    logic              ru_have, ru_have_nx;

    always_comb begin
        ru_val_nx  = ru_val_r;
        ru_idx_nx  = ru_idx_r;
        ru_have_nx = ru_have;
        if (beat) begin
            if (cnt == '0) begin
                ru_have_nx = 1'b0;
            end else if (new_best) begin
                ru_val_nx  = best_val;
                ru_idx_nx  = best_idx;
                ru_have_nx = 1'b1;
            end else if (!ru_have || better(in_data, ru_val_r, mode)) begin
                ru_val_nx  = in_data;
                ru_idx_nx  = cnt;
                ru_have_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ru_val_r <= '0;
            ru_idx_r <= '0;
            ru_have  <= 1'b0;
            ru_idx   <= '1;
            ru_val   <= '0;
        end else begin
            ru_val_r <= ru_val_nx;
            ru_idx_r <= ru_idx_nx;
            ru_have  <= ru_have_nx;
            if (last) begin
                ru_idx <= ru_idx_nx;
                ru_val <= ru_val_nx;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '1;
            res_val   <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            best_val  <= '0;
            best_idx  <= '0;
        end else begin
            in_ready <= (state_nx == RUN);
            busy     <= (state_nx == RUN);
            done     <= (state_nx == DONE);
            best_val <= best_val_nx;
            best_idx <= best_idx_nx;
            if (state == IDLE && start) begin
                cnt  <= '0;
                mode <= mode_min;
            end else if (beat) begin
                cnt <= cnt + IDX_W'(1);
            end
            if (last) begin
                res_valid <= 1'b1;
                res_idx   <= best_idx_nx;
                res_val   <= best_val_nx;
            end
        end
    end

endmodule
